// File: rtl/regfile_mp_if.sv
// Bundle of read, write and issue signals between the pipeline and the
// multi-port register file; master is the pipeline side, slave the register file.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);

  // No valid/ready: every enable is sampled and accepted on each posedge, and
  // read results are combinational functions of rd_addr and current state.
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  w0_en;
  logic [AW-1:0]         w0_addr;
  logic [XLEN-1:0]       w0_data;
  logic                  w1_en;
  logic [AW-1:0]         w1_addr;
  logic [XLEN-1:0]       w1_data;
  logic                  iss_en;
  logic [AW-1:0]         iss_addr;
  logic                  busy_any;

  modport master (
    output rd_addr, w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
           iss_en, iss_addr,
    input  rd_data, rd_busy, busy_any
  );

  modport slave (
    input  rd_addr, w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
           iss_en, iss_addr,
    output rd_data, rd_busy, busy_any
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NREAD combinational reads, two prioritised
// write ports (W1 wins), optional write-to-read bypass and a pending-write scoreboard.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             busy_any_q, busy_any_d;
  logic             w0_live, w1_live, iss_live;

  logic [NREAD*XLEN-1:0] rd_data_c;
  logic [NREAD-1:0]      rd_busy_c;
  logic [AW-1:0]         ra;

  // Writes and issues aimed at r0 are dropped here, so r0 never changes.
  assign w0_live  = bus.w0_en  && (bus.w0_addr  != '0);
  assign w1_live  = bus.w1_en  && (bus.w1_addr  != '0);
  assign iss_live = bus.iss_en && (bus.iss_addr != '0);

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (w0_live) begin
      regs_d[bus.w0_addr] = bus.w0_data;
      busy_d[bus.w0_addr] = 1'b0;
    end
    // Load writeback is younger than the ALU result, so it is applied last.
    if (w1_live) begin
      regs_d[bus.w1_addr] = bus.w1_data;
      busy_d[bus.w1_addr] = 1'b0;
    end
    // A new producer issuing in the same cycle keeps the register pending.
    if (iss_live) begin
      busy_d[bus.iss_addr] = 1'b1;
    end
    regs_d[0]  = '0;
    busy_d[0]  = 1'b0;
    busy_any_d = |busy_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_any_q <= busy_any_d;
    end
  end

  // Bypass is forced off while reset is held so outputs stay at zero.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    ra        = '0;
    for (int i = 0; i < NREAD; i++) begin
      ra = bus.rd_addr[i*AW +: AW];
      if (!reset || ra == '0) begin
        rd_data_c[i*XLEN +: XLEN] = '0;
        rd_busy_c[i]              = 1'b0;
      end else if (BYPASS != 0 && w1_live && bus.w1_addr == ra) begin
        rd_data_c[i*XLEN +: XLEN] = bus.w1_data;
        rd_busy_c[i]              = 1'b0;
      end else if (BYPASS != 0 && w0_live && bus.w0_addr == ra) begin
        rd_data_c[i*XLEN +: XLEN] = bus.w0_data;
        rd_busy_c[i]              = 1'b0;
      end else begin
        rd_data_c[i*XLEN +: XLEN] = regs_q[ra];
        rd_busy_c[i]              = busy_q[ra];
      end
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_busy  = rd_busy_c;
  assign bus.busy_any = busy_any_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing and a non-bypassing build share one stimulus
// stream; expected read results are queued by the driver and checked by a monitor.
module tb_regfile_mp;
  localparam int XLEN  = 64;
  localparam int NREGS = 16;
  localparam int NREAD = 4;
  localparam int AW    = 4;
  localparam int W     = 2 + 2*XLEN + 3;
  localparam logic [XLEN-1:0] PAT = 64'h0101010101010101;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NREAD*AW-1:0] rd_addr;
  logic                w0_en, w1_en, iss_en;
  logic [AW-1:0]       w0_addr, w1_addr, iss_addr;
  logic [XLEN-1:0]     w0_data, w1_data;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus1 ();
  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus0 ();

  assign bus1.rd_addr = rd_addr;  assign bus0.rd_addr = rd_addr;
  assign bus1.w0_en   = w0_en;    assign bus0.w0_en   = w0_en;
  assign bus1.w0_addr = w0_addr;  assign bus0.w0_addr = w0_addr;
  assign bus1.w0_data = w0_data;  assign bus0.w0_data = w0_data;
  assign bus1.w1_en   = w1_en;    assign bus0.w1_en   = w1_en;
  assign bus1.w1_addr = w1_addr;  assign bus0.w1_addr = w1_addr;
  assign bus1.w1_data = w1_data;  assign bus0.w1_data = w1_data;
  assign bus1.iss_en  = iss_en;   assign bus0.iss_en  = iss_en;
  assign bus1.iss_addr = iss_addr; assign bus0.iss_addr = iss_addr;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  logic [W-1:0]    mon_item;
  string           mon_name;
  int              mon_port;
  logic [XLEN-1:0] e_d1, e_d0, a_d1, a_d0;
  logic            e_b1, e_b0, e_ba, a_b1, a_b0, a_ba1, a_ba0;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_item = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_port = int'(mon_item[W-1 -: 2]);
      e_d1  = mon_item[XLEN+3 +: XLEN];
      e_d0  = mon_item[3 +: XLEN];
      e_b1  = mon_item[2];
      e_b0  = mon_item[1];
      e_ba  = mon_item[0];
      a_d1  = bus1.rd_data[mon_port*XLEN +: XLEN];
      a_d0  = bus0.rd_data[mon_port*XLEN +: XLEN];
      a_b1  = bus1.rd_busy[mon_port];
      a_b0  = bus0.rd_busy[mon_port];
      a_ba1 = bus1.busy_any;
      a_ba0 = bus0.busy_any;
      n_checks++;
      if (a_d1 !== e_d1 || a_d0 !== e_d0 || a_b1 !== e_b1 || a_b0 !== e_b0 ||
          a_ba1 !== e_ba || a_ba0 !== e_ba) begin
        n_errors++;
        $display("FAIL %s port%0d: got byp1 %h/%b byp0 %h/%b any %b/%b, want byp1 %h/%b byp0 %h/%b any %b",
                 mon_name, mon_port, a_d1, a_b1, a_d0, a_b0, a_ba1, a_ba0,
                 e_d1, e_b1, e_d0, e_b0, e_ba);
      end
    end
  end

  // driver tasks
  task automatic chk(input string nm, input int port, input logic [XLEN-1:0] d1,
                     input logic [XLEN-1:0] d0, input logic b1, input logic b0,
                     input logic ba);
    logic [1:0] p;
    p = port[1:0];
    exp_q.push_back({p, d1, d0, b1, b0, ba});
    name_q.push_back(nm);
  endtask

  task automatic set_rd(input int port, input int a);
    rd_addr[port*AW +: AW] = AW'(a);
  endtask

  task automatic idle();
    rd_addr = '0;
    w0_en = 1'b0; w0_addr = '0; w0_data = '0;
    w1_en = 1'b0; w1_addr = '0; w1_data = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic wr0(input int a, input logic [XLEN-1:0] d);
    w0_en = 1'b1; w0_addr = AW'(a); w0_data = d;
  endtask

  task automatic wr1(input int a, input logic [XLEN-1:0] d);
    w1_en = 1'b1; w1_addr = AW'(a); w1_data = d;
  endtask

  task automatic iss(input int a);
    iss_en = 1'b1; iss_addr = AW'(a);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    // held in reset: write and issue must neither land nor bypass
    wr0(5, 64'hDEADBEEF); iss(7); set_rd(0, 5); set_rd(1, 7);
    chk("rst_hold_r5", 0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_hold_r7", 1, '0, '0, 1'b0, 1'b0, 1'b0);
    step(); step();
    reset = 1'b1;

    // r0 hard-wire
    wr0(0, 64'h12345678); wr1(0, 64'h12345678); iss(0);
    for (int p = 0; p < NREAD; p++) chk("r0_same", p, '0, '0, 1'b0, 1'b0, 1'b0);
    step();
    for (int p = 0; p < NREAD; p++) chk("r0_after", p, '0, '0, 1'b0, 1'b0, 1'b0);
    step();

    // dual-write collision
    wr0(3, 64'hAAAA0000); wr1(3, 64'h0000BBBB); set_rd(0, 3);
    chk("coll_same", 0, 64'h0000BBBB, '0, 1'b0, 1'b0, 1'b0);
    step();
    set_rd(0, 3);
    chk("coll_after", 0, 64'h0000BBBB, 64'h0000BBBB, 1'b0, 1'b0, 1'b0);
    step();

    // bypass on/off
    wr0(9, 64'h11); set_rd(2, 9);
    chk("byp_first", 2, 64'h11, '0, 1'b0, 1'b0, 1'b0);
    step();
    wr0(9, 64'h22); set_rd(1, 9);
    chk("byp_same", 1, 64'h22, 64'h11, 1'b0, 1'b0, 1'b0);
    step();
    set_rd(1, 9);
    chk("byp_after", 1, 64'h22, 64'h22, 1'b0, 1'b0, 1'b0);
    step();

    // scoreboard set/clear race on r4
    iss(4); set_rd(2, 4);
    chk("race_pre", 2, '0, '0, 1'b0, 1'b0, 1'b0);
    step();
    set_rd(2, 4);
    chk("race_e1", 2, '0, '0, 1'b1, 1'b1, 1'b1);
    step();
    wr1(4, 64'h44); iss(4); set_rd(2, 4);
    chk("race_e2_same", 2, 64'h44, '0, 1'b0, 1'b1, 1'b1);
    step();
    wr0(4, 64'h55); set_rd(2, 4);
    chk("race_e3_same", 2, 64'h55, 64'h44, 1'b0, 1'b1, 1'b1);
    step();
    set_rd(2, 4);
    chk("race_e3_after", 2, 64'h55, 64'h55, 1'b0, 1'b0, 1'b0);
    step();

    // fill every register with addr * PAT; the last w1 aims at r0 and is dropped
    for (int a = 1; a < NREGS; a += 2) begin
      wr0(a, PAT * XLEN'(a));
      wr1((a + 1) % NREGS, PAT * XLEN'(a + 1));
      step();
    end
    set_rd(0, 1); set_rd(1, 6); set_rd(2, 11); set_rd(3, 15);
    chk("mp_a_p0", 0, 64'h0101010101010101, 64'h0101010101010101, 1'b0, 1'b0, 1'b0);
    chk("mp_a_p1", 1, 64'h0606060606060606, 64'h0606060606060606, 1'b0, 1'b0, 1'b0);
    chk("mp_a_p2", 2, 64'h0B0B0B0B0B0B0B0B, 64'h0B0B0B0B0B0B0B0B, 1'b0, 1'b0, 1'b0);
    chk("mp_a_p3", 3, 64'h0F0F0F0F0F0F0F0F, 64'h0F0F0F0F0F0F0F0F, 1'b0, 1'b0, 1'b0);
    step();
    set_rd(0, 2); set_rd(1, 7); set_rd(2, 12); set_rd(3, 0);
    chk("mp_b_p0", 0, 64'h0202020202020202, 64'h0202020202020202, 1'b0, 1'b0, 1'b0);
    chk("mp_b_p1", 1, 64'h0707070707070707, 64'h0707070707070707, 1'b0, 1'b0, 1'b0);
    chk("mp_b_p2", 2, 64'h0C0C0C0C0C0C0C0C, 64'h0C0C0C0C0C0C0C0C, 1'b0, 1'b0, 1'b0);
    chk("mp_b_p3", 3, '0, '0, 1'b0, 1'b0, 1'b0);
    step();

    // reset mid-operation
    wr0(5, 64'hDEADBEEF);
    step();
    iss(7);
    step();
    set_rd(0, 7); set_rd(1, 5);
    chk("pre_rst_r7", 0, 64'h0707070707070707, 64'h0707070707070707, 1'b1, 1'b1, 1'b1);
    chk("pre_rst_r5", 1, 64'hDEADBEEF, 64'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    step();
    reset = 1'b0;
    wr0(5, 64'h99); set_rd(0, 5); set_rd(1, 7);
    chk("rst_r5", 0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_r7", 1, '0, '0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    set_rd(0, 5); set_rd(1, 7);
    chk("post_rst_r5", 0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_r7", 1, '0, '0, 1'b0, 1'b0, 1'b0);
    step();
    step();

    // report
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
